// File: rtl/pattern_scheduler_if.sv
// Handshake bundle between frame_gen / control inputs and pattern_scheduler.
// Ports: frame, pause, req_next, req_prev (to scheduler); pattern_sel, switch, req_ack, pending (from scheduler).
interface pattern_scheduler_if #(
    parameter int NUM_PATTERNS = 4
);
    localparam int SEL_W = $clog2(NUM_PATTERNS);

    logic             frame;
    logic             pause;
    logic             req_next;
    logic             req_prev;
    logic [SEL_W-1:0] pattern_sel;
    logic             switch;
    logic             req_ack;
    logic             pending;

    modport master (
        output frame, pause, req_next, req_prev,
        input  pattern_sel, switch, req_ack, pending
    );

    modport slave (
        input  frame, pause, req_next, req_prev,
        output pattern_sel, switch, req_ack, pending
    );
endinterface

// File: rtl/pattern_scheduler.sv
// Frame-synchronous test-pattern selector: auto-advances every HOLD_FRAMES frames, takes manual next/prev steps.
// Ports: clk, reset (sync, active-high), bus (pattern_scheduler_if.slave); led only with PATTERN_SCHEDULER_HEARTBEAT_EN.
module pattern_scheduler #(
    parameter int NUM_PATTERNS  = 4,
    parameter int HOLD_FRAMES   = 60,
    parameter int START_PATTERN = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    pattern_scheduler_if.slave    bus
`ifdef PATTERN_SCHEDULER_HEARTBEAT_EN
    ,
    output logic                  led
`endif
);
    localparam int SEL_W = $clog2(NUM_PATTERNS);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [SEL_W-1:0] SEL_START = SEL_W'(START_PATTERN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_FRAMES - 1);

    logic [SEL_W-1:0] sel, sel_n, sel_inc, sel_dec;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             nxt_l, prv_l, nxt_n, prv_n;
    logic             nxt_eff, prv_eff;
    logic             sw, sw_n, ack, ack_n;

    always_comb begin
        sel_n   = sel;
        cnt_n   = cnt;
        nxt_n   = nxt_l | bus.req_next;
        prv_n   = prv_l | bus.req_prev;
        sw_n    = 1'b0;
        ack_n   = 1'b0;
        nxt_eff = nxt_l | bus.req_next;
        prv_eff = prv_l | bus.req_prev;
        // Wrap is modulo NUM_PATTERNS, not 2^SEL_W.
        sel_inc = (sel == SEL_MAX) ? '0 : sel + 1'b1;
        sel_dec = (sel == '0) ? SEL_MAX : sel - 1'b1;

        if (bus.frame) begin
            if (nxt_eff || prv_eff) begin
                // Manual step wins over auto expiry; opposing requests cancel.
                ack_n = 1'b1;
                nxt_n = 1'b0;
                prv_n = 1'b0;
                cnt_n = '0;
                if (nxt_eff && !prv_eff) begin
                    sel_n = sel_inc;
                    sw_n  = 1'b1;
                end else if (prv_eff && !nxt_eff) begin
                    sel_n = sel_dec;
                    sw_n  = 1'b1;
                end
            end else if (!bus.pause) begin
                if (cnt == CNT_LAST) begin
                    sel_n = sel_inc;
                    cnt_n = '0;
                    sw_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel   <= SEL_START;
            cnt   <= '0;
            nxt_l <= 1'b0;
            prv_l <= 1'b0;
            sw    <= 1'b0;
            ack   <= 1'b0;
        end else begin
            sel   <= sel_n;
            cnt   <= cnt_n;
            nxt_l <= nxt_n;
            prv_l <= prv_n;
            sw    <= sw_n;
            ack   <= ack_n;
        end
    end

    assign bus.pattern_sel = sel;
    assign bus.switch      = sw;
    assign bus.req_ack     = ack;
    assign bus.pending     = nxt_l | prv_l;

`ifdef PATTERN_SCHEDULER_HEARTBEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= 1'b0;
        end else if (sw_n) begin
            led <= ~led;
        end
    end
`endif
endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: directed scenarios plus random stimulus vs a reference model.
// Ports: none (top-level bench).
module tb_pattern_scheduler;
    localparam int N     = 4;
    localparam int HOLD  = 60;
    localparam int START = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_scheduler_if #(.NUM_PATTERNS(N)) bus ();

`ifdef PATTERN_SCHEDULER_HEARTBEAT_EN
    logic led;
`endif

    pattern_scheduler #(
        .NUM_PATTERNS (N),
        .HOLD_FRAMES  (HOLD),
        .START_PATTERN(START)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef PATTERN_SCHEDULER_HEARTBEAT_EN
        ,
        .led  (led)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pattern index, frames shown since last change, latched requests.
    int m_sel, m_shown;
    bit m_nl, m_pl, m_sw, m_ack, m_led;
    int sw_seen, ack_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit f, input bit p, input bit n, input bit v, input bit r);
        bit want_next, want_prev;
        m_sw  = 0;
        m_ack = 0;
        if (r) begin
            m_sel = START; m_shown = 0; m_nl = 0; m_pl = 0; m_led = 0;
        end else if (f) begin
            want_next = m_nl || n;
            want_prev = m_pl || v;
            if (want_next || want_prev) begin
                m_ack = 1; m_nl = 0; m_pl = 0; m_shown = 0;
                if (want_next != want_prev) begin
                    m_sel = want_next ? (m_sel + 1) % N : (m_sel + N - 1) % N;
                    m_sw  = 1;
                end
            end else if (!p) begin
                m_shown = m_shown + 1;
                if (m_shown == HOLD) begin
                    m_sel = (m_sel + 1) % N; m_shown = 0; m_sw = 1;
                end
            end
        end else begin
            m_nl = m_nl || n;
            m_pl = m_pl || v;
        end
        if (m_sw) m_led = !m_led;
    endtask

    task automatic cyc(input bit f, input bit p, input bit n, input bit v, input bit r);
        @(negedge clk);
        bus.frame = f; bus.pause = p; bus.req_next = n; bus.req_prev = v; reset = r;
        @(posedge clk);
        model(f, p, n, v, r);
        #1;
        check("sel", bus.pattern_sel, m_sel);
        check("switch", bus.switch, m_sw);
        check("req_ack", bus.req_ack, m_ack);
        check("pending", bus.pending, m_nl | m_pl);
`ifdef PATTERN_SCHEDULER_HEARTBEAT_EN
        check("led", led, m_led);
`endif
        sw_seen  += int'(bus.switch);
        ack_seen += int'(bus.req_ack);
    endtask

    task automatic frames(input int k, input bit p);
        for (int i = 0; i < k; i++) begin
            cyc(1, p, 0, 0, 0);
            cyc(0, p, 0, 0, 0);
            cyc(0, p, 0, 0, 0);
        end
    endtask

    initial begin
        bit pz;
        bus.frame = 0; bus.pause = 0; bus.req_next = 0; bus.req_prev = 0; reset = 1;
        m_sel = START; m_shown = 0; m_nl = 0; m_pl = 0; m_led = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("rst_sel", bus.pattern_sel, START);
        check("rst_pending", bus.pending, 0);

        // Auto advance after HOLD frames, then a full lap.
        sw_seen = 0; ack_seen = 0;
        frames(59, 0);
        check("no_sw_59", sw_seen, 0);
        cyc(1, 0, 0, 0, 0);
        check("sel_60", bus.pattern_sel, 1);
        check("sw_60", bus.switch, 1);
        check("ack_60", ack_seen, 0);
        cyc(0, 0, 0, 0, 0);
        frames(180, 0);
        check("sel_240", bus.pattern_sel, 0);
        check("sw_240", sw_seen, 4);

        // Manual next restarts the hold count.
        cyc(0, 0, 1, 0, 0);
        check("pend_set", bus.pending, 1);
        cyc(1, 0, 0, 0, 0);
        check("mn_sel", bus.pattern_sel, 1);
        check("mn_ack", bus.req_ack, 1);
        check("mn_sw", bus.switch, 1);
        check("mn_pend", bus.pending, 0);
        sw_seen = 0;
        cyc(0, 0, 0, 0, 0);
        frames(59, 0);
        check("mn_hold", sw_seen, 0);
        frames(1, 0);
        check("mn_auto_sel", bus.pattern_sel, 2);

        // Step back to 0, wrap backwards to 3, then cancelling requests.
        cyc(0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0);
        check("prv_to0", bus.pattern_sel, 0);
        cyc(0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0);
        check("prv_wrap", bus.pattern_sel, 3);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        check("cancel_sel", bus.pattern_sel, 3);
        check("cancel_ack", bus.req_ack, 1);
        check("cancel_sw", bus.switch, 0);

        // Pause freezes the counter; release resumes from the frozen count.
        cyc(0, 0, 0, 0, 0);
        frames(30, 0);
        sw_seen = 0;
        frames(200, 1);
        check("pause_nosw", sw_seen, 0);
        frames(29, 0);
        check("resume_nosw", sw_seen, 0);
        frames(1, 0);
        check("resume_sw", sw_seen, 1);
        check("resume_sel", bus.pattern_sel, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("pause_manual", bus.pattern_sel, 1);

        // Request coincident with frame is honoured at that frame.
        cyc(1, 0, 0, 1, 0);
        check("same_cyc_req", bus.pattern_sel, 0);

        // Reset while pending and counter at HOLD-1.
        cyc(0, 0, 0, 0, 1);
        frames(59, 0);
        cyc(0, 0, 1, 0, 0);
        check("pre_rst_pend", bus.pending, 1);
        cyc(0, 0, 0, 0, 1);
        check("mid_rst_sel", bus.pattern_sel, START);
        check("mid_rst_pend", bus.pending, 0);
        sw_seen = 0;
        frames(59, 0);
        check("mid_rst_hold", sw_seen, 0);

        // Random stimulus against the model.
        pz = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) pz = !pz;
            cyc($urandom_range(0, 2) == 0, pz,
                $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 1499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
